// File: rtl/tlo_thi_clk_gen.sv
// Emulated clock generator: requests timesteps so that every clk_o edge lands
// exactly on an emulator timestep boundary, alternating low/high phase durations.
module tlo_thi_clk_gen #(
    parameter int DT_WIDTH = 32
) (
    input  logic                emu_clk,
    input  logic                emu_rst,
    input  logic [DT_WIDTH-1:0] t_lo,
    input  logic [DT_WIDTH-1:0] t_hi,
    input  logic [DT_WIDTH-1:0] emu_dt,
    output logic [DT_WIDTH-1:0] dt_req,
    output logic                clk_o,
    output logic [15:0]         edge_cnt,
    output logic                err_o
);

    logic [DT_WIDTH-1:0] rem_q, rem_d;
    logic                clk_q, clk_d;
    logic [15:0]         edge_cnt_q, edge_cnt_d;
    logic                err_q, err_d;

    // A zero duration would request a zero timestep and stall the emulator.
    function automatic logic [DT_WIDTH-1:0] clamp_dur(input logic [DT_WIDTH-1:0] t);
        return (t == '0) ? DT_WIDTH'(1) : t;
    endfunction

    always_comb begin
        rem_d      = rem_q;
        clk_d      = clk_q;
        edge_cnt_d = edge_cnt_q;
        err_d      = err_q;
        if (emu_dt < rem_q) begin
            rem_d = rem_q - emu_dt;
        end else begin
            // Overshoot is flagged, but the edge still happens and the excess is dropped.
            if (emu_dt > rem_q) begin
                err_d = 1'b1;
            end
            clk_d      = ~clk_q;
            edge_cnt_d = edge_cnt_q + 16'd1;
            rem_d      = clk_q ? clamp_dur(t_lo) : clamp_dur(t_hi);
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            rem_q      <= clamp_dur(t_lo);
            clk_q      <= 1'b0;
            edge_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            clk_q      <= clk_d;
            edge_cnt_q <= edge_cnt_d;
            err_q      <= err_d;
        end
    end

    assign dt_req   = rem_q;
    assign clk_o    = clk_q;
    assign edge_cnt = edge_cnt_q;
    assign err_o    = err_q;

endmodule
